// File: rtl/systolic_sequencer.sv
// Operand sequencer and result-capture controller for an N x N
// output-stationary systolic array. Latches an A/B tile on accept,
// clears (or keeps) the accumulators, streams skewed A rows and B columns,
// waits for the array to drain, then captures the result and pulses done.
module systolic_sequencer #(
  parameter int W   = 32,
  parameter int N   = 3,
  parameter int LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_acc,
  input  logic             i_trb,
  input  logic [W*N*N-1:0] i_A,
  input  logic [W*N*N-1:0] i_B,
  input  logic [W*N*N-1:0] i_C,
  output logic [W*N-1:0]   o_a,
  output logic [W*N-1:0]   o_b,
  output logic             o_clr,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [W*N*N-1:0] o_C
);

  // Drain covers the skew of the last operand across the grid plus array latency.
  localparam int DRAIN_LEN = 2*N - 2 + LAT;
  localparam int CW        = (DRAIN_LEN < 2) ? 1 : $clog2(DRAIN_LEN + 1);
  localparam logic [CW-1:0] FEED_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CW-1:0]      cnt_r;
  logic [CW-1:0]      cnt_nxt_s;
  logic               accept_s;
  logic               cap_s;
  logic [W*N*N-1:0]   a_lat_r;
  logic [W*N*N-1:0]   b_lat_r;
  logic               acc_lat_r;
  logic               trb_lat_r;
  logic [W*N-1:0]     a_uns_s;
  logic [W*N-1:0]     b_uns_s;

  // Next-state, step counter and the accept/capture strobes.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    cap_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (i_start) begin
          accept_s    = 1'b1;
          state_nxt_s = S_CLR;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CLR: begin
        state_nxt_s = S_FEED;
        cnt_nxt_s   = '0;
      end
      S_FEED: begin
        if (cnt_r == FEED_LAST) begin
          state_nxt_s = S_DRAIN;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_nxt_s = S_DONE;
          cnt_nxt_s   = '0;
          cap_s       = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = '0;
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State and counter register; a low enable freezes the sequence.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
    end else if (i_en) begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Operand and mode latches, loaded only on an accepted start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_lat_r   <= '0;
      b_lat_r   <= '0;
      acc_lat_r <= 1'b0;
      trb_lat_r <= 1'b0;
    end else if (i_en && accept_s) begin
      a_lat_r   <= i_A;
      b_lat_r   <= i_B;
      acc_lat_r <= i_acc;
      trb_lat_r <= i_trb;
    end
  end

  // Result capture on the final drain edge; held until the next tile.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_C <= '0;
    end else if (i_en && cap_s) begin
      o_C <= i_C;
    end
  end

  // Unskewed lane values: column k of A and row k of B during FEED, zero otherwise.
  always_comb begin
    a_uns_s = '0;
    b_uns_s = '0;
    if (state_r == S_FEED) begin
      for (int j = 0; j < N; j++) begin
        a_uns_s[j*W +: W] = a_lat_r[(int'(cnt_r)*N + j)*W +: W];
        if (trb_lat_r) begin
          b_uns_s[j*W +: W] = b_lat_r[(j*N + int'(cnt_r))*W +: W];
        end else begin
          b_uns_s[j*W +: W] = b_lat_r[(int'(cnt_r)*N + j)*W +: W];
        end
      end
    end else begin
      a_uns_s = '0;
      b_uns_s = '0;
    end
  end

  // Lane 0 enters the array without delay.
  assign o_a[0 +: W] = a_uns_s[0 +: W];
  assign o_b[0 +: W] = b_uns_s[0 +: W];

  // Lane j is delayed by a j-deep register chain to form the wavefront.
  for (genvar j = 1; j < N; j++) begin : g_skew
    logic [W-1:0] a_sr_r [j];
    logic [W-1:0] b_sr_r [j];

    // Shift the lane's delay chain on every enabled cycle, in every state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int t = 0; t < j; t++) begin
          a_sr_r[t] <= '0;
          b_sr_r[t] <= '0;
        end
      end else if (i_en) begin
        a_sr_r[0] <= a_uns_s[j*W +: W];
        b_sr_r[0] <= b_uns_s[j*W +: W];
        for (int t = 1; t < j; t++) begin
          a_sr_r[t] <= a_sr_r[t-1];
          b_sr_r[t] <= b_sr_r[t-1];
        end
      end
    end

    assign o_a[j*W +: W] = a_sr_r[j-1];
    assign o_b[j*W +: W] = b_sr_r[j-1];
  end

  assign o_ready = (state_r == S_IDLE);
  assign o_busy  = (state_r != S_IDLE);
  assign o_clr   = (state_r == S_CLR) && !acc_lat_r;
  assign o_done  = (state_r == S_DONE);

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer: a PE-grid array model closes
// the loop on i_C, expected results come from plain matrix arithmetic and
// lane timing from the wavefront rule (lane j carries element k in cycle 2+k+j).
module tb_systolic_sequencer;
  localparam int W    = 32;
  localparam int N    = 3;
  localparam int LAT  = 1;
  localparam int NN   = N*N;
  localparam int PER  = 10;
  localparam int TILE = 3*N + LAT;
  localparam int NV   = 6;
  localparam int NR   = 8;

  typedef logic [W*NN-1:0] mat_t;
  typedef struct {
    mat_t a;
    mat_t b;
    logic acc;
    logic trb;
    int   stall_at;
    int   p1;
    int   p2;
    bit   chain;
    mat_t exp_c;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, en, start, acc, trb;
  mat_t A, B, C, oC;
  logic [W*N-1:0] oa, ob;
  logic clr, ready, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  always #(PER/2) clk = ~clk;

  systolic_sequencer #(.W(W), .N(N), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start),
    .i_acc(acc), .i_trb(trb), .i_A(A), .i_B(B), .i_C(C),
    .o_a(oa), .o_b(ob), .o_clr(clr), .o_ready(ready), .o_busy(busy),
    .o_done(done), .o_C(oC)
  );

  // ---------------- output-stationary PE grid model (the array) ----------
  logic [W-1:0] pa [N][N];
  logic [W-1:0] pb [N][N];
  logic [W-1:0] pacc [N][N];
  logic [W-1:0] ain [N][N];
  logic [W-1:0] bin [N][N];

  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (c == 0) ain[r][c] = oa[r*W +: W];
        else        ain[r][c] = pa[r][c-1];
        if (r == 0) bin[r][c] = ob[c*W +: W];
        else        bin[r][c] = pb[r-1][c];
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          pa[r][c] <= '0; pb[r][c] <= '0; pacc[r][c] <= '0;
        end
    end else if (en) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          pa[r][c]   <= ain[r][c];
          pb[r][c]   <= bin[r][c];
          pacc[r][c] <= clr ? '0 : pacc[r][c] + ain[r][c] * bin[r][c];
        end
    end
  end

  always_comb begin
    C = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        C[(r*N+c)*W +: W] = pacc[r][c];
  end

  // ---------------- reference arithmetic ---------------------------------
  function automatic logic [W-1:0] a_el(mat_t m, int r, int k);
    return m[(k*N+r)*W +: W];
  endfunction

  function automatic logic [W-1:0] b_el(mat_t m, int k, int c, logic t);
    return t ? m[(c*N+k)*W +: W] : m[(k*N+c)*W +: W];
  endfunction

  function automatic mat_t mm(mat_t a, mat_t b, logic t);
    mat_t res = '0;
    logic [W-1:0] s;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = '0;
        for (int k = 0; k < N; k++) s = s + a_el(a, r, k) * b_el(b, k, c, t);
        res[(r*N+c)*W +: W] = s;
      end
    return res;
  endfunction

  function automatic mat_t madd(mat_t x, mat_t y);
    mat_t res;
    for (int i = 0; i < NN; i++) res[i*W +: W] = x[i*W +: W] + y[i*W +: W];
    return res;
  endfunction

  function automatic mat_t rnd_m();
    mat_t m;
    for (int i = 0; i < NN; i++) m[i*W +: W] = $urandom;
    return m;
  endfunction

  // Lane contents required in cycle cyc after accept: element k = cyc-2-j.
  function automatic logic [W*N-1:0] exp_lanes(mat_t m, logic t, bit isb, int cyc);
    logic [W*N-1:0] res = '0;
    int k;
    for (int j = 0; j < N; j++) begin
      k = cyc - 2 - j;
      if (k >= 0 && k < N) res[j*W +: W] = isb ? b_el(m, k, j, t) : a_el(m, j, k);
    end
    return res;
  endfunction

  task automatic chk(input string nm, input mat_t act, input mat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // ---------------- per-tile capture ---------------------------------------
  logic [W*N-1:0] tr_a [64];
  logic [W*N-1:0] tr_b [64];
  logic [3:0]     tr_ctl [64];
  logic [63:0]    m_clr, m_busy, m_ready, m_done;
  int   done_cyc, last_cyc;
  mat_t res_C;
  time  t_acc, t_prev;

  task automatic run_tile(input vec_t v, input vec_t nx, input bit pre_issued);
    int guard = 0;
    if (!pre_issued) begin
      @(negedge clk);
      A = v.a; B = v.b; acc = v.acc; trb = v.trb; start = 1'b1;
    end
    while (!(ready === 1'b1 && start === 1'b1) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_wait", mat_t'(guard < 40), mat_t'(1));
    @(posedge clk);
    t_acc = $time;
    #1;
    start = 1'b0; A = rnd_m(); B = rnd_m(); acc = 1'($urandom); trb = 1'($urandom);
    done_cyc = 0; last_cyc = 0;
    m_clr = '0; m_busy = '0; m_ready = '0; m_done = '0;
    for (int cyc = 1; cyc < 64; cyc++) begin
      @(negedge clk);
      last_cyc = cyc;
      tr_a[cyc] = oa; tr_b[cyc] = ob;
      tr_ctl[cyc] = {clr, busy, ready, done};
      m_clr[cyc] = clr; m_busy[cyc] = busy; m_ready[cyc] = ready; m_done[cyc] = done;
      if (done === 1'b1 && done_cyc == 0) begin
        done_cyc = cyc;
        res_C = oC;
      end
      if (v.stall_at > 0 && cyc == v.stall_at) en = 1'b0;
      if (v.stall_at > 0 && cyc == v.stall_at + 4) en = 1'b1;
      if (done_cyc != 0 && v.chain) begin
        A = nx.a; B = nx.b; acc = nx.acc; trb = nx.trb; start = 1'b1;
        break;
      end
      start = (cyc == v.p1 || cyc == v.p2);
      if (done_cyc != 0 && cyc >= done_cyc + 2) break;
    end
  endtask

  task automatic check_tile(input vec_t v, input string tag);
    int dexp = TILE + ((v.stall_at > 0) ? 4 : 0);
    logic [63:0] e_clr = '0, e_busy = '0, e_ready = '0, e_done = '0;
    int s = v.stall_at;
    for (int c = 1; c <= last_cyc; c++) begin
      e_clr[c]   = (!v.acc && c == 1);
      e_busy[c]  = (c <= dexp);
      e_ready[c] = (c > dexp);
      e_done[c]  = (c == dexp);
    end
    chk({tag, "_clr"},   mat_t'(m_clr),   mat_t'(e_clr));
    chk({tag, "_busy"},  mat_t'(m_busy),  mat_t'(e_busy));
    chk({tag, "_ready"}, mat_t'(m_ready), mat_t'(e_ready));
    chk({tag, "_done"},  mat_t'(m_done),  mat_t'(e_done));
    chk({tag, "_C"},     res_C,           v.exp_c);
    if (s == 0) begin
      for (int c = 1; c <= last_cyc; c++) begin
        chk($sformatf("%s_oa_c%0d", tag, c), mat_t'(tr_a[c]), mat_t'(exp_lanes(v.a, v.trb, 1'b0, c)));
        chk($sformatf("%s_ob_c%0d", tag, c), mat_t'(tr_b[c]), mat_t'(exp_lanes(v.b, v.trb, 1'b1, c)));
      end
    end else begin
      for (int d = 1; d <= 4; d++) begin
        chk($sformatf("%s_frz_oa%0d", tag, d),  mat_t'(tr_a[s+d]),   mat_t'(tr_a[s]));
        chk($sformatf("%s_frz_ob%0d", tag, d),  mat_t'(tr_b[s+d]),   mat_t'(tr_b[s]));
        chk($sformatf("%s_frz_ctl%0d", tag, d), mat_t'(tr_ctl[s+d]), mat_t'(tr_ctl[s]));
      end
    end
  endtask

  // ---------------- main sequence -------------------------------------------
  vec_t vec [NV];
  vec_t rv;
  mat_t a19, ident, mns, model_c;

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; acc = 1'b0; trb = 1'b0;
    A = '0; B = '0;
    t_prev = 0;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) begin
        a19[(k*N+r)*W +: W]   = W'(3*r + k + 1);
        ident[(k*N+r)*W +: W] = (k == r) ? W'(1) : W'(0);
        mns[(r*N+k)*W +: W]   = W'(10*r + k + 2);
      end

    vec[0] = '{a19,     ident,   1'b0, 1'b0, 0, 0, 0,    1'b0, '0};
    vec[1] = '{a19,     mns,     1'b0, 1'b1, 0, 0, 0,    1'b0, '0};
    vec[2] = '{rnd_m(), rnd_m(), 1'b0, 1'b0, 0, 0, 0,    1'b1, '0};
    vec[3] = '{rnd_m(), rnd_m(), 1'b1, 1'b1, 0, 0, 0,    1'b0, '0};
    vec[4] = '{a19,     mns,     1'b0, 1'b0, 3, 0, 0,    1'b0, '0};
    vec[5] = '{rnd_m(), mns,     1'b0, 1'b0, 0, 3, TILE, 1'b0, '0};
    model_c = '0;
    for (int i = 0; i < NV; i++) begin
      vec[i].exp_c = vec[i].acc ? madd(model_c, mm(vec[i].a, vec[i].b, vec[i].trb))
                                : mm(vec[i].a, vec[i].b, vec[i].trb);
      model_c = vec[i].exp_c;
    end

    #(2*PER + 2);
    chk("rst_ready", mat_t'(ready), mat_t'(1));
    chk("rst_busy",  mat_t'(busy),  mat_t'(0));
    chk("rst_clr",   mat_t'(clr),   mat_t'(0));
    chk("rst_done",  mat_t'(done),  mat_t'(0));
    chk("rst_lanes", mat_t'({oa, ob}), mat_t'(0));
    chk("rst_C",     oC,            mat_t'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      bit pre = (i > 0) && vec[i-1].chain;
      t_prev = t_acc;
      run_tile(vec[i], vec[(i + 1 < NV) ? i + 1 : i], pre);
      check_tile(vec[i], $sformatf("vec%0d", i));
      if (pre) chk("b2b_gap", mat_t'((t_acc - t_prev) / PER), mat_t'(TILE + 1));
    end

    for (int i = 0; i < NR; i++) begin
      rv.a = rnd_m(); rv.b = rnd_m();
      rv.acc = 1'($urandom_range(0, 1)); rv.trb = 1'($urandom_range(0, 1));
      rv.stall_at = 0; rv.p1 = 0; rv.p2 = 0; rv.chain = 1'b0;
      rv.exp_c = rv.acc ? madd(model_c, mm(rv.a, rv.b, rv.trb)) : mm(rv.a, rv.b, rv.trb);
      model_c = rv.exp_c;
      run_tile(rv, rv, 1'b0);
      check_tile(rv, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of DRAIN abandons the tile.
    @(negedge clk);
    A = rnd_m(); B = rnd_m(); acc = 1'b0; trb = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  mat_t'(busy),  mat_t'(0));
    chk("mid_rst_ready", mat_t'(ready), mat_t'(1));
    chk("mid_rst_done",  mat_t'(done),  mat_t'(0));
    chk("mid_rst_C",     oC,            mat_t'(0));
    chk("mid_rst_lanes", mat_t'({oa, ob}), mat_t'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      chk("post_rst_quiet", mat_t'(seen), mat_t'(0));
    end
    rv.a = rnd_m(); rv.b = rnd_m(); rv.acc = 1'b0; rv.trb = 1'b1;
    rv.stall_at = 0; rv.p1 = 0; rv.p2 = 0; rv.chain = 1'b0;
    rv.exp_c = mm(rv.a, rv.b, rv.trb);
    run_tile(rv, rv, 1'b0);
    check_tile(rv, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(5000*PER);
    $display("FAIL watchdog: run did not finish, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
